// File: rtl/fetch_unit.sv
// Instruction fetch front end: a free-running fetch PC feeding a small circular
// queue of {pc, instr} pairs towards decode, with redirect flush and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_pc,
  input  logic [31:0]              imem_instr,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_fpc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_q    [DEPTH];
  logic [31:0]   r_instr_q [DEPTH];

  logic w_pop;
  logic w_push;

  // Handshake decode: a full queue still accepts a push when the head leaves.
  always_comb begin
    w_pop  = (r_count != '0) && out_ready;
    w_push = !redirect_valid && !halt && ((r_count < CW'(DEPTH)) || w_pop);
  end

  // Outputs come straight from the fetch PC and the head slot.
  always_comb begin
    imem_pc   = r_fpc;
    out_valid = (r_count != '0);
    out_pc    = r_pc_q[r_head];
    out_instr = r_instr_q[r_head];
    fq_count  = r_count;
  end

  // Fetch PC, queue pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_fpc   <= redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc  <= r_fpc + 32'd1;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: cleared on reset, written at the tail on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_q[r_tail]    <= r_fpc;
      r_instr_q[r_tail] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a table of single-cycle vectors, a few hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned    DEPTH    = 2;
  localparam logic [31:0]    RESET_PC = 32'h0;
  localparam int unsigned    CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   imem_pc;
  logic [31:0]   imem_instr;
  logic          halt;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] fq_count;

  logic [31:0] salt = 32'h0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds A000+k (plus a salt in the random phase).
  assign imem_instr = 32'hA000 + imem_pc + salt;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fq_count(fq_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic h, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    reset = rst; halt = h; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        h;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] e_imem;
    int          e_cnt;
    logic [31:0] e_pc;    // checked only when e_cnt != 0 or rst
  } vec_t;

  vec_t vt [14];

  // Reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_qpc   [$];
  logic [31:0] m_qins  [$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // {rst, halt, redirect, rpc, ready, exp imem_pc, exp count, exp head pc}
    vt[0]  = '{1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0};
    vt[1]  = '{0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0};
    vt[2]  = '{0, 0, 0, 32'h0,        0, 32'h1,        1, 32'h0};
    vt[3]  = '{0, 0, 0, 32'h0,        0, 32'h2,        2, 32'h0};
    vt[4]  = '{0, 0, 0, 32'h0,        0, 32'h2,        2, 32'h0};
    vt[5]  = '{0, 0, 0, 32'h0,        1, 32'h3,        2, 32'h1};
    vt[6]  = '{0, 0, 1, 32'd40,       1, 32'd40,       0, 32'h0};
    vt[7]  = '{0, 0, 0, 32'h0,        0, 32'd41,       1, 32'd40};
    vt[8]  = '{0, 1, 0, 32'h0,        1, 32'd41,       0, 32'h0};
    vt[9]  = '{0, 1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 32'h0};
    vt[10] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFF};
    vt[11] = '{0, 0, 0, 32'h0,        1, 32'h1,        1, 32'h0};
    vt[12] = '{0, 0, 0, 32'h0,        0, 32'h2,        2, 32'h0};
    vt[13] = '{1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0};

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].rst, vt[i].h, vt[i].rv, vt[i].rpc, vt[i].rdy);
      step();
      chk($sformatf("vec%0d imem_pc", i), imem_pc, vt[i].e_imem);
      chk($sformatf("vec%0d fq_count", i), 32'(fq_count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_cnt != 0));
      if (vt[i].e_cnt != 0 || vt[i].rst) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, vt[i].e_pc);
        chk($sformatf("vec%0d out_instr", i), out_instr,
            vt[i].rst ? 32'h0 : 32'hA000 + vt[i].e_pc);
      end
    end

    // Streaming from reset: pcs 0,1,2,... one per cycle, one cycle latency.
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d out_pc", k), out_pc, 32'(k));
      chk($sformatf("stream%0d out_instr", k), out_instr, 32'hA000 + 32'(k));
    end

    // Redirect with queue holding 5,6: 5 is consumed, 6 dropped, 40 follows.
    drive(0, 0, 1, 32'd5, 0);
    step();
    drive(0, 0, 0, 32'h0, 0);
    step();
    step();
    chk("redir full count", 32'(fq_count), 32'd2);
    chk("redir head pc5", out_pc, 32'd5);
    drive(0, 0, 1, 32'd40, 1);
    #1;
    chk("redir pop valid", 32'(out_valid), 32'd1);
    step();
    chk("redir flushed count", 32'(fq_count), 32'd0);
    chk("redir imem_pc", imem_pc, 32'd40);
    drive(0, 0, 0, 32'h0, 1);
    step();
    chk("redir new head", out_pc, 32'd40);
    chk("redir new instr", out_instr, 32'hA000 + 32'd40);

    // Reset pulse on a full queue discards all entries.
    drive(0, 0, 0, 32'h0, 0);
    step();
    chk("prereset full", 32'(fq_count), 32'd2);
    drive(1, 0, 1, 32'd77, 1);
    step();
    chk("midreset count", 32'(fq_count), 32'd0);
    chk("midreset valid", 32'(out_valid), 32'd0);
    chk("midreset imem_pc", imem_pc, RESET_PC);

    // Randomized traffic against a queue model.
    salt = $urandom;
    m_fpc = RESET_PC;
    m_qpc.delete();
    m_qins.delete();
    for (int c = 0; c < 3000; c++) begin
      logic rst, h, rv, rdy, pop, push;
      logic [31:0] rpc;
      rst = (c == 0) || ($urandom_range(0, 63) == 0);
      h   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      drive(rst, h, rv, rpc, rdy);
      #1;
      if (c > 0) begin
        chk("rnd imem_pc", imem_pc, m_fpc);
        chk("rnd fq_count", 32'(fq_count), 32'(m_qpc.size()));
        chk("rnd out_valid", 32'(out_valid), 32'(m_qpc.size() != 0));
        if (m_qpc.size() != 0) begin
          chk("rnd out_pc", out_pc, m_qpc[0]);
          chk("rnd out_instr", out_instr, m_qins[0]);
        end
      end
      if (rst) begin
        m_qpc.delete();
        m_qins.delete();
        m_fpc = RESET_PC;
      end else begin
        pop  = (m_qpc.size() != 0) && rdy;
        push = !rv && !h && ((m_qpc.size() < DEPTH) || pop);
        if (pop) begin
          void'(m_qpc.pop_front());
          void'(m_qins.pop_front());
        end
        if (rv) begin
          m_qpc.delete();
          m_qins.delete();
          m_fpc = rpc;
        end else if (push) begin
          m_qpc.push_back(m_fpc);
          m_qins.push_back(32'hA000 + m_fpc + salt);
          m_fpc = m_fpc + 32'd1;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, giving the word address loaded into the fetch PC on reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the fetch-queue entry count; legal values are powers of two from 2 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_pc, output, 32 bits: word address driven to instruction memory.
REQ-006 The block SHALL have port imem_instr, input, 32 bits: combinational read data from instruction memory for imem_pc, same cycle.
REQ-007 The block SHALL have port halt, input, 1 bit: suppresses new fetches while high.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: redirect target word address.
REQ-010 The block SHALL have port out_valid, output, 1 bit: queue head holds a valid instruction.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 The block SHALL have port out_instr, output, 32 bits: head instruction.
REQ-013 The block SHALL have port out_pc, output, 32 bits: PC of the head instruction.
REQ-014 The block SHALL have port fq_count, output, clog2(DEPTH)+1 bits: current queue occupancy.

Function
REQ-015 The block SHALL hold a fetch PC register fpc and drive imem_pc = fpc combinationally.
REQ-016 The block SHALL define pop = out_valid && out_ready.
REQ-017 The block SHALL define push = !redirect_valid && !halt && (fq_count < DEPTH || pop).
REQ-018 On push, the block SHALL write {fpc, imem_instr} at the queue tail and set fpc <= fpc + 1, wrapping from 32'hFFFFFFFF to 0.
REQ-019 When neither push nor redirect occurs, fpc SHALL hold its value.
REQ-020 The queue SHALL be FIFO with circular head/tail pointers wrapping modulo DEPTH; simultaneous push and pop SHALL leave fq_count unchanged, including when the queue is full.
REQ-021 out_valid SHALL equal (fq_count != 0).
REQ-022 out_instr and out_pc SHALL be driven from the head entry with no added latency.
REQ-023 Fetch-to-out_valid latency SHALL be exactly one cycle: an instruction pushed at edge N is visible at the head after edge N when the queue was empty.
REQ-024 When redirect_valid is high, a pop in the same cycle SHALL complete normally (the head is consumed).
REQ-025 When redirect_valid is high, all remaining entries SHALL be discarded: fq_count <= 0 and head and tail pointers are reset.
REQ-026 When redirect_valid is high, fpc SHALL load redirect_pc and no push SHALL occur that cycle.
REQ-027 redirect_valid SHALL take priority over halt; fpc loads redirect_pc even while halt = 1.
REQ-028 While halt = 1, pops SHALL continue, so the queue drains.
REQ-029 out_instr and out_pc are don't-care while out_valid = 0, except immediately after reset.
REQ-030 fq_count SHALL never exceed DEPTH and never underflow; pop is impossible when empty by REQ-016.

Reset
REQ-031 While reset = 1, the block SHALL set fpc <= RESET_PC, fq_count <= 0, head/tail pointers <= 0, and all queue storage <= 0.
REQ-032 The cycle after reset deasserts, the outputs SHALL be: imem_pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, fq_count = 0.
REQ-033 Reset SHALL override redirect_valid, halt and out_ready, including reset asserted mid-stream with a full queue, which discards all entries.

Verification
REQ-034 Streaming: memory word k = 32'hA000+k, out_ready = 1, halt = 0 -> out_valid rises 1 cycle after reset release; out_pc = 0,1,2,... and out_instr = A000,A001,... on consecutive cycles.
REQ-035 Backpressure: out_ready = 0 for 5 cycles -> fq_count saturates at DEPTH (2); imem_pc stalls at 2; then out_ready = 1 -> pcs 0,1,2,3 delivered in order with no loss or duplication.
REQ-036 Redirect: queue holding pcs 5,6, redirect_pc = 40 with out_ready = 1 -> pc 5 consumed, pc 6 discarded; next cycle imem_pc = 40; following cycle out_pc = 40.
REQ-037 Halt plus redirect: halt = 1, queue drained, redirect_pc = 100 -> fpc = 100, no push while halt = 1; release halt -> out_pc = 100 appears 1 cycle later.
REQ-038 Wrap: redirect_pc = 32'hFFFFFFFF, streaming -> out_pc sequence FFFFFFFF then 0.
REQ-039 Reset mid-operation: full queue, reset pulsed for 1 cycle -> fq_count = 0, out_valid = 0, imem_pc = RESET_PC the next cycle.
